sdram_test_top: RTL and testbench
=================================

Name: sdram_test_top

Overview:
- FPGA top level that initialises an external 16-bit SDR SDRAM (13-bit row/column address, 4 banks).
- Writes a known pattern to a block of locations, reads it back and compares every word.
- Reports progress and pass/fail on three LEDs.
- Runs from a single 25 MHz system clock (40 ns period); the SDRAM clock is a forwarded, inverted copy of it.

Parameters:
- INIT_WAIT, 2500, power-up NOP cycles before init (100 us at 25 MHz)
- REFRESH_INTERVAL, 192, cycles between auto-refreshes (< 7.8 us)
- TEST_WORDS, 256, number of words written and checked
- READ_CAPTURE, 3, clk edges after the READ-issuing edge at which DQ is sampled (CL=2 plus inverted-clock register stage)

Ports:
- clk  in  1  25 MHz system clock
- locked  in  1  synchronous active-low reset (PLL lock); low = reset
- led  out  3  [0] init done, [1] test passed, [2] error (sticky)
- SDRAM_CLK  out  1  equals ~clk
- SDRAM_CKE  out  1  clock enable
- SDRAM_CS_N, SDRAM_RAS_N, SDRAM_CAS_N, SDRAM_WE_N  out  1 each  command
- SDRAM_A  out  13  address
- SDRAM_BA  out  2  bank
- SDRAM_DQ  inout  16  data; high-Z unless writing
- SDRAM_DQML, SDRAM_DQMH  out  1 each  byte masks

Behaviour:
- One clock (clk); reset is synchronous and active-low on locked. All registers update on clk rising edge.
- Command encoding {CS_N,RAS_N,CAS_N,WE_N}:
  - INHIBIT 1111
  - NOP 0111
  - ACTIVE 0011
  - READ 0101
  - WRITE 0100
  - PRECHARGE 0010
  - REFRESH 0001
  - LOAD_MODE 0000
- While locked=0 (reset values): led=000, CKE=0, command INHIBIT, A=0, BA=0, DQ high-Z, DQML=DQMH=1, all counters cleared, state POWERUP. locked low at any point aborts the current operation the same way.
- Init sequence:
  - POWERUP: CKE=1, NOP for INIT_WAIT cycles.
  - PRECHARGE all (A10=1), then 2 NOP.
  - REFRESH, then 3 NOP; REFRESH, then 3 NOP.
  - LOAD_MODE with BA=0, A=13'h020 (burst length 1, sequential, CL=2, burst write), then 2 NOP.
  - Then set led[0]=1 and DQML=DQMH=0, and go to WRITE phase.
- Write access for word n (0..TEST_WORDS-1):
  - ACTIVE, BA=0, A=row 0.
  - NOP.
  - WRITE with A10=1 (auto-precharge), A[9:0]=n, DQ driven with {8'hA5, n[7:0]} for this cycle only.
  - 3 NOP.
- Read access for word n:
  - ACTIVE, NOP, READ with A10=1 and column n, then NOP until capture.
  - DQ sampled READ_CAPTURE edges after the READ edge.
  - Compared to {8'hA5, n[7:0]}; any mismatch sets led[2]=1 (sticky until reset).
  - 1 NOP after capture before the next command.
- Sequencing:
  - Writes n=0..TEST_WORDS-1, then reads n=0..TEST_WORDS-1.
  - After the last compare: led[1]=1 if led[2]=0; then enter DONE.
- Refresh:
  - A free-running counter starts after init and counts REFRESH_INTERVAL cycles, then raises a pending flag.
  - Pending is serviced only between accesses (all banks closed): REFRESH followed by 3 NOP, then the flag clears.
  - Pending raised during an access waits for that access to complete.
  - Refresh continues in DONE.
- DONE: NOP forever apart from refreshes; LEDs hold.
- DQ drive is enabled only in the WRITE command cycle; otherwise high-Z. SDRAM_CLK is combinationally ~clk, including during reset.
- Word counter is 9 bits wide, so it does not wrap for TEST_WORDS=256; it compares against TEST_WORDS-1 to end each phase.

Test Plan:
- Hold locked=0 for 2 cycles -> led=000, CKE=0, CS_N=1, DQ=Z, DQM=11.
- Release locked -> CKE=1, NOPs for 2500 cycles, then PRECHARGE with A10=1, two REFRESHes, LOAD_MODE with A=0x020; led[0]=1 right after the final 2 NOPs.
- SDRAM model attached, run 1 ms -> 256 WRITEs then 256 READs, each preceded by ACTIVE; led=011 at end.
- Model corrupts word 17 to 16'h0000 -> led[2]=1, led[1]=0 after test; led[2] stays set.
- Monitor refresh spacing over the test -> REFRESH never issued while a bank is open; gap between REFRESHes at most REFRESH_INTERVAL plus one access length (about 12 cycles).
- Pull locked low mid-read, then release -> immediate reset values, init restarts from POWERUP, test passes again.

Source files
------------

// File: rtl/sdram_test_top.sv
// sdram_test_top
//   Power-up initialisation and write/read-back self test for a 16-bit SDR
//   SDRAM (13-bit address, 4 banks).
//   The test writes {8'hA5, n[7:0]} to column n of bank 0, row 0, for n = 0..TEST_WORDS-1.
//   It then reads every word back and compares it.
//   Auto-refresh is interleaved between accesses.
//
// Ports
//   clk         system clock (25 MHz)
//   locked      synchronous active-low reset (PLL lock)
//   led[0]      init done, led[1] test passed, led[2] error (sticky)
//   SDRAM_CLK   inverted copy of clk
//   SDRAM_CKE   clock enable
//   SDRAM_CS_N/RAS_N/CAS_N/WE_N   command
//   SDRAM_A, SDRAM_BA             address / bank
//   SDRAM_DQ    data, driven only in the WRITE command cycle
//   SDRAM_DQML/DQMH               byte masks
module sdram_test_top #(
  parameter int INIT_WAIT        = 2500,
  parameter int REFRESH_INTERVAL = 192,
  parameter int TEST_WORDS       = 256,
  parameter int READ_CAPTURE     = 3    // must be >= 2
) (
  input  logic        clk,
  input  logic        locked,
  output logic [2:0]  led,
  output logic        SDRAM_CLK,
  output logic        SDRAM_CKE,
  output logic        SDRAM_CS_N,
  output logic        SDRAM_RAS_N,
  output logic        SDRAM_CAS_N,
  output logic        SDRAM_WE_N,
  output logic [12:0] SDRAM_A,
  output logic [1:0]  SDRAM_BA,
  inout  wire  [15:0] SDRAM_DQ,
  output logic        SDRAM_DQML,
  output logic        SDRAM_DQMH
);

  localparam logic [3:0] CMD_INHIBIT = 4'b1111;
  localparam logic [3:0] CMD_NOP     = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE  = 4'b0011;
  localparam logic [3:0] CMD_READ    = 4'b0101;
  localparam logic [3:0] CMD_WRITE   = 4'b0100;
  localparam logic [3:0] CMD_PRE     = 4'b0010;
  localparam logic [3:0] CMD_REFRESH = 4'b0001;
  localparam logic [3:0] CMD_LMR     = 4'b0000;

  typedef enum logic [3:0] {
    ST_POWERUP, ST_PRECHARGE, ST_REF1, ST_REF2, ST_LOAD_MODE,
    ST_WAIT, ST_IDLE, ST_ACCESS, ST_CAPTURE, ST_REF_WAIT
  } state_t;

  state_t       state_q, state_d, ret_q, ret_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [8:0]   word_q, word_d;
  logic         rd_phase_q, rd_phase_d;
  logic         done_q, done_d;
  logic [15:0]  ref_cnt_q, ref_cnt_d;
  logic         ref_pend_q, ref_pend_d;
  logic [2:0]   led_q, led_d;
  logic         cke_q, cke_d;
  logic [3:0]   cmd_q, cmd_d;
  logic [12:0]  a_q, a_d;
  logic [1:0]   ba_q, ba_d;
  logic         dqm_q, dqm_d;
  logic         dq_oe_q, dq_oe_d;
  logic [15:0]  dq_out_q, dq_out_d;
  logic [15:0]  data_exp;
  logic         mismatch;

  assign data_exp = {8'hA5, word_q[7:0]};

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    rd_phase_d = rd_phase_q;
    done_d     = done_q;
    ref_cnt_d  = ref_cnt_q;
    ref_pend_d = ref_pend_q;
    led_d      = led_q;
    cke_d      = 1'b1;
    cmd_d      = CMD_NOP;
    a_d        = '0;
    ba_d       = '0;
    dqm_d      = dqm_q;
    dq_oe_d    = 1'b0;
    dq_out_d   = dq_out_q;
    mismatch   = 1'b0;

    // Each state decides the command placed on the bus at this edge.
    unique case (state_q)
      ST_POWERUP: begin
        if (cnt_q == 16'(INIT_WAIT - 1)) begin
          cnt_d   = '0;
          state_d = ST_PRECHARGE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_PRECHARGE: begin
        cmd_d     = CMD_PRE;
        a_d[10]   = 1'b1;               // all banks
        cnt_d     = 16'd2;
        ret_d     = ST_REF1;
        state_d   = ST_WAIT;
      end
      ST_REF1: begin
        cmd_d   = CMD_REFRESH;
        cnt_d   = 16'd3;
        ret_d   = ST_REF2;
        state_d = ST_WAIT;
      end
      ST_REF2: begin
        cmd_d   = CMD_REFRESH;
        cnt_d   = 16'd3;
        ret_d   = ST_LOAD_MODE;
        state_d = ST_WAIT;
      end
      ST_LOAD_MODE: begin
        cmd_d   = CMD_LMR;
        a_d     = 13'h020;              // BL=1, sequential, CL=2, burst write
        cnt_d   = 16'd2;
        ret_d   = ST_IDLE;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin                    // cnt_q NOPs, then ret_q
        if (cnt_q <= 16'd1) state_d = ret_q;
        else cnt_d = cnt_q - 16'd1;
      end
      ST_IDLE: begin                    // all banks closed here
        led_d[0] = 1'b1;
        dqm_d    = 1'b0;
        if (ref_pend_q) begin
          cmd_d   = CMD_REFRESH;
          cnt_d   = 16'd3;
          state_d = ST_REF_WAIT;
        end else if (!done_q) begin
          cmd_d   = CMD_ACTIVE;         // bank 0, row 0
          cnt_d   = 16'd1;
          ret_d   = ST_ACCESS;
          state_d = ST_WAIT;
        end
      end
      ST_ACCESS: begin
        a_d = {2'b00, 1'b1, 1'b0, word_q};   // A10 = auto-precharge
        if (!rd_phase_q) begin
          cmd_d    = CMD_WRITE;
          dq_oe_d  = 1'b1;
          dq_out_d = data_exp;
          cnt_d    = 16'd3;
          ret_d    = ST_IDLE;
          state_d  = ST_WAIT;
          if (word_q == 9'(TEST_WORDS - 1)) begin
            word_d     = '0;
            rd_phase_d = 1'b1;
          end else begin
            word_d = word_q + 9'd1;
          end
        end else begin
          cmd_d   = CMD_READ;
          cnt_d   = 16'(READ_CAPTURE - 1);
          ret_d   = ST_CAPTURE;
          state_d = ST_WAIT;
        end
      end
      ST_CAPTURE: begin                 // sample DQ; this edge's NOP is the gap after capture
        mismatch = (SDRAM_DQ != data_exp);
        if (mismatch) led_d[2] = 1'b1;
        if (word_q == 9'(TEST_WORDS - 1)) begin
          done_d   = 1'b1;
          led_d[1] = !(led_q[2] || mismatch);
          word_d   = '0;
        end else begin
          word_d = word_q + 9'd1;
        end
        state_d = ST_IDLE;
      end
      ST_REF_WAIT: begin
        if (cnt_q <= 16'd1) begin
          ref_pend_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = ST_POWERUP;
    endcase

    // Refresh timer runs once init is done; placed last so a new request
    // raised in the same cycle as a clear is not lost.
    if (led_q[0]) begin
      if (ref_cnt_q == 16'(REFRESH_INTERVAL - 1)) begin
        ref_cnt_d  = '0;
        ref_pend_d = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!locked) begin
      state_q    <= ST_POWERUP;
      ret_q      <= ST_POWERUP;
      cnt_q      <= '0;
      word_q     <= '0;
      rd_phase_q <= 1'b0;
      done_q     <= 1'b0;
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
      led_q      <= '0;
      cke_q      <= 1'b0;
      cmd_q      <= CMD_INHIBIT;
      a_q        <= '0;
      ba_q       <= '0;
      dqm_q      <= 1'b1;
      dq_oe_q    <= 1'b0;
      dq_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      rd_phase_q <= rd_phase_d;
      done_q     <= done_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      led_q      <= led_d;
      cke_q      <= cke_d;
      cmd_q      <= cmd_d;
      a_q        <= a_d;
      ba_q       <= ba_d;
      dqm_q      <= dqm_d;
      dq_oe_q    <= dq_oe_d;
      dq_out_q   <= dq_out_d;
    end
  end

  assign SDRAM_CLK   = ~clk;
  assign SDRAM_CKE   = cke_q;
  assign {SDRAM_CS_N, SDRAM_RAS_N, SDRAM_CAS_N, SDRAM_WE_N} = cmd_q;
  assign SDRAM_A     = a_q;
  assign SDRAM_BA    = ba_q;
  assign SDRAM_DQML  = dqm_q;
  assign SDRAM_DQMH  = dqm_q;
  assign SDRAM_DQ    = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign led         = led_q;

endmodule

// File: tb/tb_sdram_test_top.sv
// tb_sdram_test_top
//   Drives sdram_test_top against a small behavioural SDRAM (CL=2, BL=1).
//   A scoreboard queue holds the expected non-NOP command stream.
//   A monitor pops the queue on every command the DUT issues and compares it.
//   ACTIVE and post-init REFRESH are checked by rule instead of by queue.
module tb_sdram_test_top;

  localparam int INIT_WAIT = 2500;
  localparam int RI        = 192;
  localparam int WORDS     = 256;

  localparam logic [3:0] C_INH = 4'b1111, C_NOP = 4'b0111, C_ACT = 4'b0011,
                         C_RD  = 4'b0101, C_WR  = 4'b0100, C_PRE = 4'b0010,
                         C_REF = 4'b0001, C_LMR = 4'b0000;

  logic        clk, locked;
  logic [2:0]  led;
  logic        SDRAM_CLK, SDRAM_CKE, SDRAM_CS_N, SDRAM_RAS_N, SDRAM_CAS_N, SDRAM_WE_N;
  logic [12:0] SDRAM_A;
  logic [1:0]  SDRAM_BA;
  wire  [15:0] SDRAM_DQ;
  logic        SDRAM_DQML, SDRAM_DQMH;

  sdram_test_top dut (
    .clk(clk), .locked(locked), .led(led),
    .SDRAM_CLK(SDRAM_CLK), .SDRAM_CKE(SDRAM_CKE),
    .SDRAM_CS_N(SDRAM_CS_N), .SDRAM_RAS_N(SDRAM_RAS_N),
    .SDRAM_CAS_N(SDRAM_CAS_N), .SDRAM_WE_N(SDRAM_WE_N),
    .SDRAM_A(SDRAM_A), .SDRAM_BA(SDRAM_BA), .SDRAM_DQ(SDRAM_DQ),
    .SDRAM_DQML(SDRAM_DQML), .SDRAM_DQMH(SDRAM_DQMH)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- SDRAM model ----------------
  logic [15:0] mem [0:511];
  logic        mdl_oe = 1'b0;
  logic [15:0] mdl_dq = '0;
  int          rd_wait = 0;
  bit          corrupt = 0;
  logic        tb_oe = 1'b0;
  logic [15:0] tb_dq = '0;

  assign SDRAM_DQ = mdl_oe ? mdl_dq : 16'hzzzz;
  assign SDRAM_DQ = tb_oe  ? tb_dq  : 16'hzzzz;

  // Commands are taken on SDRAM_CLK rising (clk falling). Read data appears
  // two SDRAM clocks after READ and is held for one clock.
  always @(negedge clk) begin
    logic [3:0] c;
    c = {SDRAM_CS_N, SDRAM_RAS_N, SDRAM_CAS_N, SDRAM_WE_N};
    if (!locked) begin
      mdl_oe  <= 1'b0;
      rd_wait <= 0;
    end else begin
      mdl_oe <= (rd_wait == 1);
      if (rd_wait > 0) rd_wait <= rd_wait - 1;
      if (c == C_WR) mem[SDRAM_A[8:0]] = SDRAM_DQ;
      else if (c == C_RD) begin
        mdl_dq  <= (corrupt && SDRAM_A[8:0] == 9'd17) ? 16'h0000 : mem[SDRAM_A[8:0]];
        rd_wait <= 2;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [3:0]  cmd;
    logic [12:0] a;
    logic [12:0] amask;
    logic [1:0]  ba;
    logic [15:0] dq;
    bit          chk_dq;
    int          gap;   // required preceding NOP count, -1 = any
    int          idx;
  } exp_t;

  exp_t exp_q[$];

  function automatic void push(input logic [3:0] c, input logic [12:0] a, input logic [12:0] m,
                               input logic [15:0] d, input bit cd, input int g, input int i);
    exp_t e;
    e.cmd = c; e.a = a; e.amask = m; e.ba = 2'd0; e.dq = d; e.chk_dq = cd; e.gap = g; e.idx = i;
    exp_q.push_back(e);
  endfunction

  function automatic void push_run();
    exp_q.delete();
    push(C_PRE, 13'h400, 13'h400, '0, 0, INIT_WAIT, -1);
    push(C_REF, 13'h000, 13'h000, '0, 0, 2, -1);
    push(C_REF, 13'h000, 13'h000, '0, 0, 3, -1);
    push(C_LMR, 13'h020, 13'h1FFF, '0, 0, 3, -1);
    for (int n = 0; n < WORDS; n++)
      push(C_WR, 13'h400 | 13'(n), 13'h1FFF, {8'hA5, 8'(n)}, 1, -1, n);
    for (int n = 0; n < WORDS; n++)
      push(C_RD, 13'h400 | 13'(n), 13'h1FFF, '0, 0, -1, n);
  endfunction

  // ---------------- monitor ----------------
  int nop_run = 0;
  bit init_seen = 0, first_act = 0, bank_open = 0;
  int last_ref = 0, ref_count = 0, reads_seen = 0;

  always @(negedge clk) begin
    logic [3:0] c;
    exp_t e;
    c = {SDRAM_CS_N, SDRAM_RAS_N, SDRAM_CAS_N, SDRAM_WE_N};
    if (!locked || c == C_INH) begin
      nop_run = 0; init_seen = 0; first_act = 0; bank_open = 0;
    end else if (c == C_NOP) begin
      nop_run++;
    end else begin
      if (c == C_ACT) begin
        checks++;
        if (bank_open || SDRAM_A != 13'd0 || SDRAM_BA != 2'd0 ||
            (first_act && (nop_run != 2 || led[0] != 1'b1 || SDRAM_DQML != 1'b0 || SDRAM_DQMH != 1'b0))) begin
          errors++;
          $display("FAIL active open=%0d a=%h ba=%0d gap=%0d led=%b dqm=%b%b required closed a=0 ba=0 (first: gap=2 led0=1 dqm=00)",
                   bank_open, SDRAM_A, SDRAM_BA, nop_run, led, SDRAM_DQMH, SDRAM_DQML);
        end
        if (first_act) last_ref = cyc;
        first_act = 0;
        bank_open = 1;
      end else if (c == C_REF && init_seen) begin
        checks++;
        if (bank_open || (cyc - last_ref) > RI + 12) begin
          errors++;
          $display("FAIL refresh open=%0d gap=%0d required closed gap<=%0d", bank_open, cyc - last_ref, RI + 12);
        end
        $display("%0t refresh gap=%0d", $time, cyc - last_ref);
        last_ref = cyc;
        ref_count++;
      end else if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected cmd=%b a=%h required no command", c, SDRAM_A);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (c != e.cmd || (SDRAM_A & e.amask) != (e.a & e.amask) || SDRAM_BA != e.ba ||
            (e.chk_dq && SDRAM_DQ != e.dq) || (e.gap >= 0 && nop_run != e.gap) ||
            (c == C_LMR && led[0] != 1'b0)) begin
          errors++;
          $display("FAIL sb_cmd idx=%0d cmd=%b a=%h ba=%0d dq=%h gap=%0d led0=%b required cmd=%b a=%h mask=%h ba=%0d dq=%h gap=%0d",
                   e.idx, c, SDRAM_A, SDRAM_BA, SDRAM_DQ, nop_run, led[0],
                   e.cmd, e.a, e.amask, e.ba, e.dq, e.gap);
        end else begin
          $display("%0t cmd=%b idx=%0d a=%h dq=%h ok", $time, c, e.idx, SDRAM_A, SDRAM_DQ);
        end
        if (c == C_LMR) begin init_seen = 1; first_act = 1; end
        if (c == C_RD) reads_seen++;
        if (c == C_RD || c == C_WR || c == C_PRE) bank_open = 0;
      end
      nop_run = 0;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end else begin
      $display("%0t %s=%h ok", $time, name, got);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_led"}, 32'(led), 32'h0);
    chk({tag, "_cke"}, 32'(SDRAM_CKE), 32'h0);
    chk({tag, "_cmd"}, 32'({SDRAM_CS_N, SDRAM_RAS_N, SDRAM_CAS_N, SDRAM_WE_N}), 32'hF);
    chk({tag, "_dqm"}, 32'({SDRAM_DQMH, SDRAM_DQML}), 32'h3);
    chk({tag, "_addr"}, 32'({SDRAM_BA, SDRAM_A}), 32'h0);
  endtask

  // Waits for the scoreboard to drain (last READ issued), then for its capture.
  task automatic wait_run(input int budget, input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout left=%0d required 0 within %0d cycles", tag, exp_q.size(), budget);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic start_run();
    @(negedge clk);
    locked = 1'b0;
    repeat (2) @(negedge clk);
    push_run();
    reads_seen = 0;
    locked = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r0, n;
    locked = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("rst");
    tb_oe = 1'b1; tb_dq = 16'h0000; #1;
    chk("rst_dq_lo", 32'(SDRAM_DQ), 32'h0000);
    tb_dq = 16'hFFFF; #1;
    chk("rst_dq_hi", 32'(SDRAM_DQ), 32'hFFFF);
    tb_oe = 1'b0;

    // Run 1: clean pass
    corrupt = 0;
    start_run();
    wait_run(12000, "run1");
    chk("run1_led", 32'(led), 32'h3);

    // Run 2: word 17 reads back as zero
    corrupt = 1;
    start_run();
    wait_run(12000, "run2");
    chk("run2_led", 32'(led), 32'h5);
    r0 = ref_count;
    repeat (600) @(negedge clk);
    chk("run2_led_hold", 32'(led), 32'h5);
    chk("done_refresh", 32'(ref_count - r0 >= 2), 32'h1);

    // Run 3: reset in the middle of the read phase, then a full clean run
    corrupt = 0;
    start_run();
    n = 0;
    while (reads_seen < 40 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk("run3_reads_reached", 32'(reads_seen >= 40), 32'h1);
    locked = 1'b0;
    @(negedge clk);
    check_reset("midrst");
    @(negedge clk);
    push_run();
    reads_seen = 0;
    locked = 1'b1;
    wait_run(12000, "run3");
    chk("run3_led", 32'(led), 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
